// File: rtl/stream_demux_1x2.sv
// Registered 1-to-2 stream demultiplexer: routes each accepted input word to one of
// two one-entry output registers, each with its own wrapping transfer counter.
module stream_demux_1x2 #(
    parameter int DW    = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    input  logic             in_select,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [DW-1:0]    out1_data,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic [DW-1:0]    out2_data,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
    // The producer holds data/select stable while valid=1 and ready=0; outputs hold
    // data/valid stable while valid=1 and ready=0. ready never waits on valid.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ch_state_t;

    ch_state_t        st1_q, st1_d, st2_q, st2_d;
    logic [DW-1:0]    data1_q, data2_q;
    logic [CNT_W-1:0] cnt1_q, cnt2_q;
    logic             load1, load2, drain1, drain2;

    assign out1_valid = (st1_q == FULL);
    assign out2_valid = (st2_q == FULL);
    assign out1_data  = data1_q;
    assign out2_data  = data2_q;
    assign cnt1       = cnt1_q;
    assign cnt2       = cnt2_q;

    // A channel can take a word if empty or if it drains on this same edge.
    assign in_ready = !rst && (in_select ? (!out1_valid || out1_ready)
                                         : (!out2_valid || out2_ready));

    assign load1  = in_valid && in_ready && in_select;
    assign load2  = in_valid && in_ready && !in_select;
    assign drain1 = out1_valid && out1_ready;
    assign drain2 = out2_valid && out2_ready;

    always_comb begin
        st1_d = st1_q;
        st2_d = st2_q;
        if (load1)       st1_d = FULL;
        else if (drain1) st1_d = EMPTY;
        if (load2)       st2_d = FULL;
        else if (drain2) st2_d = EMPTY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st1_q   <= EMPTY;
            st2_q   <= EMPTY;
            data1_q <= '0;
            data2_q <= '0;
            cnt1_q  <= '0;
            cnt2_q  <= '0;
        end else begin
            st1_q <= st1_d;
            st2_q <= st2_d;
            if (load1)  data1_q <= in_data;
            if (load2)  data2_q <= in_data;
            if (drain1) cnt1_q  <= cnt1_q + 1'b1;
            if (drain2) cnt2_q  <= cnt2_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_stream_demux_1x2.sv
// Bench for stream_demux_1x2: directed cases plus a random run against a queue-based
// model; a second instance with CNT_W=2 shares the stimulus to exercise counter wrap.
module tb_stream_demux_1x2;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0, in_select = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out1_ready = 1'b0, out2_ready = 1'b0;
    logic          in_ready, out1_valid, out2_valid;
    logic [DW-1:0] out1_data, out2_data;
    logic [7:0]    cnt1, cnt2;

    logic          w_in_ready, w_out1_valid, w_out2_valid;
    logic [DW-1:0] w_out1_data, w_out2_data;
    logic [1:0]    w_cnt1, w_cnt2;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] exp_q1[$];
    logic [DW-1:0] exp_q2[$];
    int            c1 = 0, c2 = 0;
    logic          last_acc = 1'b1;

    always #5 clk = ~clk;

    stream_demux_1x2 #(.DW(DW), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_select(in_select),
        .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
        .out2_valid(out2_valid), .out2_ready(out2_ready), .out2_data(out2_data),
        .cnt1(cnt1), .cnt2(cnt2)
    );

    stream_demux_1x2 #(.DW(DW), .CNT_W(2)) dut_wrap (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_data(in_data), .in_select(in_select),
        .out1_valid(w_out1_valid), .out1_ready(out1_ready), .out1_data(w_out1_data),
        .out2_valid(w_out2_valid), .out2_ready(out2_ready), .out2_data(w_out2_data),
        .cnt1(w_cnt1), .cnt2(w_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("out1_valid", out1_valid, exp_q1.size() != 0);
        check("out2_valid", out2_valid, exp_q2.size() != 0);
        if (exp_q1.size() != 0) check("out1_data", out1_data, exp_q1[0]);
        if (exp_q2.size() != 0) check("out2_data", out2_data, exp_q2[0]);
        check("cnt1", cnt1, c1 % 256);
        check("cnt2", cnt2, c2 % 256);
        check("wrap_cnt1", w_cnt1, c1 % 4);
        check("wrap_cnt2", w_cnt2, c2 % 4);
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic cycle(input logic v, input logic s, input logic [DW-1:0] d,
                         input logic r1, input logic r2);
        logic exp_rdy, dr1, dr2;
        in_valid = v; in_select = s; in_data = d; out1_ready = r1; out2_ready = r2;
        #1;
        exp_rdy = s ? (exp_q1.size() == 0 || r1) : (exp_q2.size() == 0 || r2);
        check("in_ready", in_ready, exp_rdy);
        check("wrap_in_ready", w_in_ready, exp_rdy);
        last_acc = v && exp_rdy;
        dr1 = (exp_q1.size() != 0) && r1;
        dr2 = (exp_q2.size() != 0) && r2;
        @(posedge clk);
        #1;
        if (dr1) begin void'(exp_q1.pop_front()); c1++; end
        if (dr2) begin void'(exp_q2.pop_front()); c2++; end
        if (last_acc) begin
            if (s) exp_q1.push_back(d);
            else   exp_q2.push_back(d);
        end
        check_outputs();
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_out1_valid", out1_valid, 0);
        check("rst_out2_valid", out2_valid, 0);
        check("rst_out1_data", out1_data, 0);
        check("rst_out2_data", out2_data, 0);
        check("rst_cnt1", cnt1, 0);
        check("rst_cnt2", cnt2, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_wrap_cnt2", w_cnt2, 0);
        exp_q1.delete(); exp_q2.delete(); c1 = 0; c2 = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [1:0] wexp[5];
    logic       pv, ps;
    logic [DW-1:0] pd;

    initial begin
        wexp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        @(negedge clk);
        do_reset();

        // Back-to-back on channel 1
        cycle(1, 1, 4'h1, 1, 1);
        check("b2b_d1", out1_data, 4'h1);
        cycle(1, 1, 4'h2, 1, 1);
        check("b2b_d2", out1_data, 4'h2);
        cycle(1, 1, 4'h3, 1, 1);
        check("b2b_d3", out1_data, 4'h3);
        cycle(0, 1, 4'h0, 1, 1);
        check("b2b_cnt1", cnt1, 3);

        // Routing sweep
        for (int s = 0; s < 2; s++)
            for (int d = 0; d < 16; d++)
                cycle(1, s[0], d[DW-1:0], 1, 1);
        cycle(0, 0, 4'h0, 1, 1);

        // Backpressure on channel 1 while channel 2 flows
        cycle(1, 1, 4'hA, 0, 1);
        check("bp_hold_a", out1_data, 4'hA);
        cycle(1, 0, 4'h3, 0, 1);
        check("bp_pass_3", out2_data, 4'h3);
        cycle(1, 1, 4'h5, 0, 1);
        check("bp_stall_5", out1_data, 4'hA);
        cycle(1, 1, 4'h5, 1, 1);
        check("bp_after_5", out1_data, 4'h5);
        cycle(0, 1, 4'h0, 1, 1);

        // Counter wrap on the CNT_W=2 instance
        do_reset();
        cycle(1, 0, 4'h0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(i < 4, 0, 4'(i + 1), 1, 1);
            check("wrap_seq", w_cnt2, wexp[i]);
        end

        // Reset with both channels full
        cycle(1, 1, 4'h7, 0, 0);
        cycle(1, 0, 4'h9, 0, 0);
        check("full1", out1_valid, 1);
        check("full2", out2_valid, 1);
        do_reset();

        // Random run
        pv = 1'b0; ps = 1'b0; pd = '0; last_acc = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (!(pv && !last_acc)) begin
                pv = ($urandom_range(0, 3) != 0);
                ps = 1'($urandom_range(0, 1));
                pd = DW'($urandom_range(0, 15));
            end
            cycle(pv, ps, pd, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end
        cycle(0, 0, 4'h0, 1, 1);
        check("drained1", out1_valid, 0);
        check("drained2", out2_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
        $finish;
    end

endmodule
